// File: rtl/rf_multiport.sv
// Multi-port register file for the decode stage: combinational read ports,
// one writeback port, and a per-register busy scoreboard with a pending count.
module rf_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] read_result,
    output logic [READ_PORTS-1:0]            read_busy,
    input  logic                             write_enable,
    input  logic [ADDR_WIDTH-1:0]            write_addr,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic                             reserve_enable,
    input  logic [ADDR_WIDTH-1:0]            reserve_addr,
    output logic [ADDR_WIDTH:0]              busy_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;

    logic wr_ok;
    logic rs_ok;
    logic cnt_inc;
    logic cnt_dec;

    assign wr_ok = write_enable && !is_zero_reg(write_addr);
    assign rs_ok = reserve_enable && !is_zero_reg(reserve_addr);

    // Reserve is applied after the write so a same-edge new producer keeps the flag set.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[write_addr] = 1'b0;
        end
        if (rs_ok) begin
            busy_d[reserve_addr] = 1'b1;
        end
    end

    assign cnt_inc = rs_ok && !busy_q[reserve_addr];
    assign cnt_dec = wr_ok && busy_q[write_addr] && !(rs_ok && (reserve_addr == write_addr));

    always_comb begin
        count_d = count_q;
        if (cnt_inc && !cnt_dec) begin
            count_d = count_q + CNT_ONE;
        end else if (cnt_dec && !cnt_inc) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[write_addr] <= write_data;
            end
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_count = count_q;

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic                  hit;
        logic [DATA_WIDTH-1:0] rd_data;
        logic                  rd_busy;

        assign addr = read_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit  = (BYPASS != 0) && wr_ok && (write_addr == addr);

        always_comb begin
            rd_data = regs_q[addr];
            rd_busy = busy_q[addr];
            if (is_zero_reg(addr)) begin
                rd_data = '0;
                rd_busy = 1'b0;
            end else if (hit) begin
                rd_data = write_data;
                rd_busy = rs_ok && (reserve_addr == addr);
            end
        end

        assign read_result[k*DATA_WIDTH +: DATA_WIDTH] = rd_data;
        assign read_busy[k] = rd_busy;
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: directed scenarios plus randomized traffic checked
// against a behavioural register-file model, on a bypass and a no-bypass build.
module tb_rf_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RP = 2;
    localparam int DEPTH = 32;

    logic            clk;
    logic            reset;
    logic [RP*AW-1:0] read_addr;
    logic            write_enable;
    logic [AW-1:0]   write_addr;
    logic [DW-1:0]   write_data;
    logic            reserve_enable;
    logic [AW-1:0]   reserve_addr;

    logic [RP*DW-1:0] res_b, res_n;
    logic [RP-1:0]    rb_b, rb_n;
    logic [AW:0]      bc_b, bc_n;

    rf_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .BYPASS(1), .ZERO_REG(1)) dut_byp (
        .clk(clk), .reset(reset), .read_addr(read_addr), .read_result(res_b), .read_busy(rb_b),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .reserve_enable(reserve_enable), .reserve_addr(reserve_addr), .busy_count(bc_b));

    rf_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .BYPASS(0), .ZERO_REG(1)) dut_nob (
        .clk(clk), .reset(reset), .read_addr(read_addr), .read_result(res_n), .read_busy(rb_n),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .reserve_enable(reserve_enable), .reserve_addr(reserve_addr), .busy_count(bc_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: contents and busy flags as plain arrays.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_busy[i];
        return n;
    endfunction

    function automatic logic [DW-1:0] m_read(input int a, input bit byp);
        if (a == 0) return '0;
        if (byp && write_enable && (int'(write_addr) == a)) return write_data;
        return m_mem[a];
    endfunction

    function automatic logic m_rbusy(input int a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && write_enable && (int'(write_addr) == a))
            return reserve_enable && (int'(reserve_addr) == a);
        return m_busy[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (write_enable && write_addr != 0) begin
                m_mem[write_addr]  = write_data;
                m_busy[write_addr] = 1'b0;
            end
            if (reserve_enable && reserve_addr != 0) m_busy[reserve_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; write_enable = 1'b0; reserve_enable = 1'b0;
        write_addr = '0; write_data = '0; reserve_addr = '0;
    endtask

    task automatic set_raddr(input int a0, input int a1);
        read_addr[0 +: AW]  = AW'(a0);
        read_addr[AW +: AW] = AW'(a1);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            set_raddr(a, a);
            #1;
            checks++;
            if (res_b !== '0 || rb_b !== '0 || bc_b !== '0 || res_n !== '0 || rb_n !== '0 || bc_n !== '0) begin
                errors++;
                $display("FAIL reset_r%0d: result=%h busy=%b count=%0d (nobyp %h %b %0d), required all zero",
                         a, res_b, rb_b, bc_b, res_n, rb_n, bc_n);
            end
        end
    endtask

    task automatic test_basic();
        idle_inputs();
        write_enable = 1'b1; write_addr = 5; write_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        set_raddr(5, 0);
        #1;
        checks++;
        if (res_b[0 +: DW] !== 32'hDEADBEEF || res_n[0 +: DW] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_r5: got %h/%h required deadbeef", res_b[0 +: DW], res_n[0 +: DW]);
        end
        write_enable = 1'b1; write_addr = 0; write_data = 32'h12345678;
        set_raddr(0, 0);
        #1;
        checks++;
        if (res_b !== '0) begin
            errors++;
            $display("FAIL zero_bypass: got %h required 0", res_b);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (res_b !== '0 || res_n !== '0 || bc_b !== 0 || bc_n !== 0) begin
            errors++;
            $display("FAIL zero_reg: got %h/%h count %0d/%0d required 0", res_b, res_n, bc_b, bc_n);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        write_enable = 1'b1; write_addr = 7; write_data = 32'hA5A5A5A5;
        set_raddr(0, 7);
        #1;
        checks++;
        if (res_b[DW +: DW] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_fwd: got %h required a5a5a5a5", res_b[DW +: DW]);
        end
        checks++;
        if (res_n[DW +: DW] !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_old: got %h required 0", res_n[DW +: DW]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (res_n[DW +: DW] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL nobypass_next: got %h required a5a5a5a5", res_n[DW +: DW]);
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        reserve_enable = 1'b1; reserve_addr = 3;
        tick();
        reserve_addr = 4;
        tick();
        idle_inputs();
        set_raddr(3, 4);
        #1;
        checks++;
        if (bc_b !== 2 || rb_b !== 2'b11 || bc_n !== 2 || rb_n !== 2'b11) begin
            errors++;
            $display("FAIL sb_reserve: count %0d/%0d busy %b/%b required 2 and 11", bc_b, bc_n, rb_b, rb_n);
        end
        write_enable = 1'b1; write_addr = 3; write_data = 32'h1;
        tick();
        idle_inputs();
        checks++;
        if (bc_b !== 1 || rb_b !== 2'b10) begin
            errors++;
            $display("FAIL sb_retire: count %0d busy %b required 1 and 10", bc_b, rb_b);
        end
        reserve_enable = 1'b1; reserve_addr = 4;
        tick();
        checks++;
        if (bc_b !== 1) begin
            errors++;
            $display("FAIL sb_rereserve: count %0d required 1", bc_b);
        end
        reserve_addr = 0;
        tick();
        idle_inputs();
        set_raddr(0, 4);
        #1;
        checks++;
        if (bc_b !== 1 || rb_b !== 2'b10) begin
            errors++;
            $display("FAIL sb_reserve_r0: count %0d busy %b required 1 and 10", bc_b, rb_b);
        end
    endtask

    task automatic test_collision();
        idle_inputs();
        reserve_enable = 1'b1; reserve_addr = 9;
        tick();
        write_enable = 1'b1; write_addr = 9; write_data = 32'h55;
        set_raddr(9, 9);
        #1;
        checks++;
        if (res_b[0 +: DW] !== 32'h55 || rb_b[0] !== 1'b1) begin
            errors++;
            $display("FAIL coll_bypass: got %h busy %b required 55 busy 1", res_b[0 +: DW], rb_b[0]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (res_b[0 +: DW] !== 32'h55 || rb_b[0] !== 1'b1 || bc_b !== 2) begin
            errors++;
            $display("FAIL coll_after: got %h busy %b count %0d required 55 1 2", res_b[0 +: DW], rb_b[0], bc_b);
        end
        write_enable = 1'b1; write_addr = 9; write_data = 32'h66;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rb_b[0] !== 1'b0 || bc_b !== 1 || res_b[0 +: DW] !== 32'h66) begin
            errors++;
            $display("FAIL coll_retire: busy %b count %0d data %h required 0 1 66", rb_b[0], bc_b, res_b[0 +: DW]);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        reserve_enable = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            reserve_addr = AW'(r);
            tick();
        end
        idle_inputs();
        checks++;
        if (bc_b !== 10) begin
            errors++;
            $display("FAIL mid_count10: count %0d required 10", bc_b);
        end
        reset = 1'b1; write_enable = 1'b1; write_addr = 2; write_data = 32'hFF;
        tick();
        idle_inputs();
        checks++;
        if (bc_b !== 0 || bc_n !== 0) begin
            errors++;
            $display("FAIL mid_count0: count %0d/%0d required 0", bc_b, bc_n);
        end
        for (int a = 0; a < DEPTH; a++) begin
            set_raddr(a, 2);
            #1;
            checks++;
            if (rb_b !== 2'b00 || res_b[DW +: DW] !== 32'h0 || res_b[0 +: DW] !== 32'h0) begin
                errors++;
                $display("FAIL mid_clear_r%0d: data %h busy %b required 0", a, res_b, rb_b);
            end
        end
    endtask

    task automatic test_random();
        int a [RP];
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset          = ($urandom_range(0, 59) == 0);
            write_enable   = $urandom_range(0, 1);
            reserve_enable = $urandom_range(0, 1);
            write_addr     = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            reserve_addr   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            write_data     = $urandom;
            for (int k = 0; k < RP; k++) begin
                a[k] = ($urandom_range(0, 2) == 0) ? int'(write_addr) : $urandom_range(0, 7);
                read_addr[k*AW +: AW] = AW'(a[k]);
            end
            #1;
            for (int k = 0; k < RP; k++) begin
                checks++;
                if (res_b[k*DW +: DW] !== m_read(a[k], 1'b1) || rb_b[k] !== m_rbusy(a[k], 1'b1)) begin
                    errors++;
                    $display("FAIL rand_byp c%0d p%0d r%0d: data %h busy %b required %h %b", cyc, k, a[k],
                             res_b[k*DW +: DW], rb_b[k], m_read(a[k], 1'b1), m_rbusy(a[k], 1'b1));
                end
                checks++;
                if (res_n[k*DW +: DW] !== m_read(a[k], 1'b0) || rb_n[k] !== m_rbusy(a[k], 1'b0)) begin
                    errors++;
                    $display("FAIL rand_nob c%0d p%0d r%0d: data %h busy %b required %h %b", cyc, k, a[k],
                             res_n[k*DW +: DW], rb_n[k], m_read(a[k], 1'b0), m_rbusy(a[k], 1'b0));
                end
            end
            checks++;
            if (int'(bc_b) != m_count() || int'(bc_n) != m_count()) begin
                errors++;
                $display("FAIL rand_count c%0d: count %0d/%0d required %0d", cyc, bc_b, bc_n, m_count());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        read_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        #2;
        test_reset();
        test_basic();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
